// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage feeding the processor core. Owns the program
// counter, issues single-outstanding reads to instruction memory and buffers
// up to two fetched words (with their PC+4) in a small FIFO. The head entry
// is offered to the processor under a valid/ready handshake. Branch/jump
// redirects flush the FIFO and any in-flight fetch.
//
// Parameters
//   RESET_PC     fetch address after reset (must be word aligned)
//
// Ports
//   clk          in   1   clock, all state on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   imem_req     out  1   read request, held until imem_ack
//   imem_addr    out  32  word-aligned read address, stable while imem_req
//   imem_ack     in   1   request accepted, imem_rdata valid this cycle
//   imem_rdata   in   32  instruction word (valid with imem_ack)
//   redirect     in   1   taken branch/jump pulse
//   redirect_pc  in   32  new fetch target, sampled with redirect
//   Instruction  out  32  FIFO head instruction
//   PC_Plus4     out  32  FIFO head fetch address + 4
//   instr_valid  out  1   FIFO head holds a valid entry
//   instr_ready  in   1   processor consumes the head this cycle
//   align_err    out  1   sticky: a redirect target had nonzero bits [1:0]
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] Instruction,
    output logic [31:0] PC_Plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        align_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_fetch_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_fifo_instr [2];
    logic [31:0] r_fifo_pc4   [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;
    logic        r_align_err;

    logic        w_req;
    logic        w_hs;
    logic        w_push;
    logic        w_pop;
    logic        w_fifo_full;
    logic [31:0] w_redirect_aligned;
    logic [31:0] w_req_addr_inc;

    assign w_fifo_full        = (r_count == 2'd2);
    assign w_hs               = w_req & imem_ack;
    assign w_pop              = instr_valid & instr_ready;
    // A redirect kills the word arriving on the same edge.
    assign w_push             = (r_state == ST_FETCH) & w_hs & ~redirect;
    assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
    assign w_req_addr_inc     = r_req_addr + 32'd4;

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state and request generation. imem_req depends only on the
    // state and fill level, never on redirect or instr_ready, so a pop on a
    // full FIFO does not open a request until the following cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                w_req = ~w_fifo_full;
                // Memory is mid-handshake on the old address: keep it stable
                // and throw the eventual data away.
                if (redirect && w_req && !imem_ack) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                w_req = 1'b1;
                if (imem_ack) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // PC, request address, FIFO and sticky alignment error
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc  <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= '0;
            r_align_err <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc4[i]   <= '0;
            end
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_aligned;
            r_count    <= '0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                r_align_err <= 1'b1;
            end
            // Only a pending, unacknowledged request pins the old address;
            // every other case (including a discard completing on this edge)
            // moves straight to the newest target.
            if (w_state_nxt != ST_DISCARD) begin
                r_req_addr <= w_redirect_aligned;
            end
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= imem_rdata;
                r_fifo_pc4[r_wr_ptr]   <= w_req_addr_inc;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            case (r_state)
                ST_FETCH: begin
                    if (w_hs) begin
                        r_fetch_pc <= w_req_addr_inc;
                        r_req_addr <= w_req_addr_inc;
                    end else if (!w_req) begin
                        r_req_addr <= r_fetch_pc;
                    end
                end
                ST_DISCARD: begin
                    if (imem_ack) begin
                        r_req_addr <= r_fetch_pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: all registered, head data never bypasses from imem_rdata
    // -----------------------------------------------------------------------
    assign imem_req    = w_req;
    assign imem_addr   = r_req_addr;
    assign instr_valid = (r_count != 2'd0);
    assign Instruction = r_fifo_instr[r_rd_ptr];
    assign PC_Plus4    = r_fifo_pc4[r_rd_ptr];
    assign align_err   = r_align_err;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage sitting directly upstream of `CS3421_RRK_Processor`. Owns the program counter, issues one-outstanding-request reads to instruction memory, and buffers up to two fetched words in a FIFO. Presents `Instruction` and `PC_Plus4` to the processor under a valid/ready handshake. Accepts branch/jump redirects from the processor and flushes all stale fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch address loaded on reset; low 2 bits must be 0.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  read request to instruction memory; held until `imem_ack`.
- `imem_addr`  out  32  word-aligned read address; stable while `imem_req` is high.
- `imem_ack`  in  1  request accepted and `imem_rdata` valid this cycle; ignored when `imem_req` is low.
- `imem_rdata`  in  32  instruction word, valid only with `imem_ack`.
- `redirect`  in  1  one-cycle pulse: taken branch or jump.
- `redirect_pc`  in  32  new fetch target, sampled when `redirect` is high.
- `Instruction`  out  32  FIFO head instruction.
- `PC_Plus4`  out  32  FIFO head's fetch address + 4.
- `instr_valid`  out  1  FIFO head holds a valid entry.
- `instr_ready`  in  1  processor consumes head this cycle.
- `align_err`  out  1  sticky; set when a redirect target has nonzero bits [1:0].

## Operation
- State: `fetch_pc` (32), `req_addr` (32), 2-entry FIFO of {instr, pc+4}, `count` (0..2), FSM {IDLE, FETCH, DISCARD}.
- Reset: FSM=IDLE, `fetch_pc`=`req_addr`=RESET_PC, `count`=0, FIFO contents 0, `align_err`=0. Outputs under reset: `imem_req`=0, `imem_addr`=RESET_PC, `Instruction`=0, `PC_Plus4`=0, `instr_valid`=0.
- IDLE -> FETCH unconditionally on the first edge after `rst_n` rises.
- `imem_req` = (FETCH and `count`<2) or DISCARD. `imem_addr` = `req_addr`.
- FETCH, `req_addr` tracks `fetch_pc` while no request is pending. On edge with `imem_req`&`imem_ack`: push {`imem_rdata`, `req_addr`+4}; `fetch_pc`, `req_addr` <= `req_addr`+4.
- Pop on edge with `instr_valid`&`instr_ready`. Push and pop on the same edge: `count` unchanged, order preserved.
- `count`==2: no request issued, even if a pop occurs that cycle (request resumes the next cycle).
- `redirect` has priority over push and pop on the same edge. `count`<=0 and `fetch_pc`<=`redirect_pc`&~3. `align_err`<=1 if `redirect_pc`[1:0]!=0.
  - If `imem_req` is high without `imem_ack`: go to DISCARD, keep `req_addr` (old address) so memory sees a stable request.
  - Otherwise, including an ack on the same edge (data dropped): stay in FETCH and set `req_addr`<=new `fetch_pc`.
- DISCARD: hold `imem_req` high on the old `req_addr`. On ack, drop the data, set `req_addr`<=`fetch_pc`, return to FETCH. A further `redirect` in DISCARD only updates `fetch_pc` (last redirect wins).
- Address arithmetic is mod 2^32: 32'hFFFF_FFFC+4 = 0.
- Async reset mid-request abandons it. Memory must tolerate `imem_req` dropping without ack.

## Timing
- First `imem_req` is in the 2nd cycle after reset release (one IDLE cycle).
- Ack at edge k: `instr_valid`=1 in the cycle after k. Head outputs come from FIFO registers, never combinationally from `imem_rdata`.
- With a zero-wait memory (ack whenever req) and `instr_ready` held at 1: one instruction per cycle, no bubbles.
- Redirect at edge E: `instr_valid`=0 in the cycle after E. New-target request in the cycle after E, or in the cycle after the discard ack.
- No combinational path from `instr_ready` or `redirect` to `imem_addr`. The only such path to `imem_req` is from FSM/`count`.

## Test plan
- Reset release, zero-wait memory returning addr-derived words, `instr_ready`=1 → req addresses 0,4,8,…; outputs (`imem_rdata`@0, PC_Plus4=4), (@4, 8), one per cycle.
- `instr_ready`=0 for 5 cycles → exactly 2 entries held, `imem_req`=0; `instr_ready`=1 → entries 0 then 4 drain in order, fetching resumes at 8.
- Memory with 3-cycle ack latency, `redirect` to 32'h100 on the second wait cycle → old ack data never appears; next request is 32'h100; first valid output has PC_Plus4=32'h104.
- `redirect` on the same edge as an ack and a pop with `count`=2 → `count`=0, `instr_valid`=0 next cycle, next req at the target.
- `redirect_pc`=32'h0000_0106 → fetch from 32'h104, `align_err`=1 and stays 1 until reset; `RESET_PC`=32'hFFFF_FFF8 → fetches FFF8, FFFC, 0000_0000 (wrap).
- Assert `rst_n`=0 mid-wait with `count`=1 → all outputs at reset values immediately (async), restart from `RESET_PC`.
